// File: rtl/fpcvt_expander.sv
// fpcvt_expander: rebuilds a 12-bit two's-complement linear value from a
// compressed FPCVT sample (sign S, exponent E, significand F).
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   S/E/F hold a sample
//   in_ready   block can accept a sample (IDLE only)
//   S, E, F    compressed sample: sign, exponent 0..7, significand 0..15
//   out_valid  D_out holds a finished result (HOLD only)
//   out_ready  consumer accepts D_out
//   D_out      reconstructed value, two's complement
//   busy       high in SHIFT or HOLD
//
// State  | meaning
// IDLE   | waiting for a sample, in_ready high
// SHIFT  | denormalising, one left shift per clock while cnt != 0
// HOLD   | result presented on D_out until the consumer takes it
module fpcvt_expander #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             S,
  input  logic [2:0]       E,
  input  logic [3:0]       F,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] D_out,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [OUT_W-1:0] ONE = 1;

  state_t           state;
  state_t           state_nxt;
  logic             sgn;
  logic [2:0]       cnt;
  logic [OUT_W-1:0] mag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)  state_nxt = SHIFT;
      SHIFT:   if (cnt == 3'd0) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // cnt is a down-counter; the terminal count (0) is the edge that
  // publishes the result, so a sample with E shifts takes E+1 clocks.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sgn   <= 1'b0;
      cnt   <= 3'd0;
      mag   <= '0;
      D_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sgn <= S;
            cnt <= E;
            mag <= {{(OUT_W-4){1'b0}}, F};
          end
        end
        SHIFT: begin
          if (cnt != 3'd0) begin
            mag <= mag << 1;
            cnt <= cnt - 3'd1;
          end else begin
            // Magnitude tops out at 1920, so negation never overflows and
            // a negative zero naturally comes out as 0.
            D_out <= sgn ? (~mag + ONE) : mag;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == HOLD);
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_fpcvt_expander.sv
module tb_fpcvt_expander;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        S;
  logic [2:0]  E;
  logic [3:0]  F;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] D_out;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int accepted = 0;
  int transfers = 0;
  logic [11:0] exp_q[$];

  fpcvt_expander #(.OUT_W(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S(S), .E(E), .F(F), .out_valid(out_valid), .out_ready(out_ready),
    .D_out(D_out), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Reference: value = (-1)^S * F * 2^E, as a 12-bit two's-complement word.
  function automatic logic [11:0] ref_expand(input bit s, input int e, input int f);
    int v;
    v = f * (1 << e);
    if (s) v = -v;
    return v[11:0];
  endfunction

  // Compressor model: smallest exponent whose significand fits 4 bits,
  // truncating low bits; magnitudes beyond 1920 saturate to E=7, F=15.
  task automatic compress(input logic [11:0] d, output bit s, output int e, output int f);
    int v;
    int m;
    v = $signed(d);
    s = (v < 0);
    m = s ? -v : v;
    if (m > 1920) begin
      e = 7;
      f = 15;
    end else begin
      e = 0;
      while ((m >> e) > 15) e++;
      f = m >> e;
    end
  endtask

  // Scoreboard monitor: a transfer happens at the next rising edge whenever
  // out_valid and out_ready are both high at the falling edge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      transfers++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 32'd1, 32'd0);
      end else begin
        logic [11:0] want;
        want = exp_q.pop_front();
        check("d_out", D_out, want);
      end
      check("busy_in_hold", busy, 1'b1);
    end
  end

  // Issues one sample and returns once out_valid is seen (sampled #1 after
  // the edge), checking latency against E+1.
  task automatic send(input bit s, input int e, input int f);
    int cyc;
    bit ok;
    S = s; E = e[2:0]; F = f[3:0]; in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      check("accept_timeout", 32'd1, 32'd0);
    end else begin
      exp_q.push_back(ref_expand(s, e, f));
      accepted++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    S = 1'($urandom); E = 3'($urandom); F = 4'($urandom);
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) break;
      @(posedge clk); #1;
      cyc++;
    end
    check("latency", cyc, e + 1);
  endtask

  task automatic wait_idle();
    bit ok;
    out_ready = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk); #1;
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    bit rs;
    int re, rf;
    logic [11:0] rt_d;
    logic [11:0] held;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; S = 1'b0; E = '0; F = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_d_out", D_out, 12'h000);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;

    out_ready = 1'b1;
    send(1'b0, 2, 11);
    check("pos_44", D_out, 12'h02C);
    check("in_ready_low_hold", in_ready, 1'b0);
    @(posedge clk); #1;
    check("idle_after_xfer", in_ready, 1'b1);
    check("out_valid_dropped", out_valid, 1'b0);

    send(1'b1, 7, 15);  check("neg_sat", D_out, 12'h880);  wait_idle();
    send(1'b0, 7, 15);  check("pos_sat", D_out, 12'h780);  wait_idle();
    send(1'b0, 0, 9);   check("e0", D_out, 12'h009);       wait_idle();
    send(1'b1, 3, 0);   check("neg_zero", D_out, 12'h000); wait_idle();

    // Backpressure with a competing sample waiting on the input.
    out_ready = 1'b0;
    send(1'b0, 4, 5);
    S = 1'b1; E = 3'd1; F = 4'd3; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_d_out", D_out, 12'h050);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_back_idle", in_ready, 1'b1);
    check("bp_valid_low", out_valid, 1'b0);
    exp_q.push_back(ref_expand(1'b1, 1, 3));
    accepted++;
    @(posedge clk); #1;
    check("bp_new_taken", busy, 1'b1);
    in_valid = 1'b0;
    wait_idle();

    // Reset two clocks into a long shift.
    S = 1'b0; E = 3'd6; F = 4'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("mid_accepted", busy, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_d_out", D_out, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    send(1'b1, 5, 9); check("post_rst", D_out, 12'hEE0); wait_idle();

    // Round trip through a compressor model.
    for (int k = 0; k < 3; k++) begin
      rt_d = (k == 0) ? 12'h02D : (k == 1) ? 12'h07D : 12'h7FF;
      compress(rt_d, rs, re, rf);
      send(rs, re, rf);
      if (k == 0) check("rt_02d", D_out, 12'h02C);
      if (k == 2) check("rt_7ff", D_out, 12'h780);
      wait_idle();
    end

    // Randomized samples with random consumer stalls.
    for (int n = 0; n < 40; n++) begin
      out_ready = 1'($urandom);
      send(1'($urandom), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
      if (!out_ready) begin
        held = D_out;
        repeat ($urandom_range(1, 4)) @(posedge clk);
        #1;
        check("rand_hold_stable", D_out, held);
      end
      wait_idle();
    end

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    check("transfer_count", transfers, accepted);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
